hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 4-stage (IF/ID/EX/MEM/WB register set) 8-bit datapath. Keeps a shadow pipeline of destination and load/flag metadata for the ID_EX, EX_MEM and MEM_WB stages. From that state it drives the datapath's `forward_A`, `forward_B`, `forward_mem` and `pc_mux` selects, plus `flush`, `push`, `pop` and stall controls. It sits between the main decoder, which is ID-stage combinational, and the DataPath.

## Interface
Parameters:
- `REG_AW`, 3: register address width.
- `INST_W`, 19: instruction width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `id_inst` in `INST_W`: IF_ID instruction.
  - src A = [10:8].
  - src B = [7:5], or [13:11] when `id_reg_B_mux`=1.
  - dst = [13:11].
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_alu_B_mux`, `id_reg_B_mux`, `id_flag_write` in 1 each: ID-stage decode.
- `id_uses_A`, `id_uses_B` in 1 each: operand actually read.
- `id_branch_sel` in 2: 00 none, 01 BZ (taken if Z=1), 10 BNZ (taken if Z=0), 11 BC (taken if C=1).
- `id_jump`, `id_call`, `id_ret` in 1 each.
- `C`, `Z` in 1 each: architectural flags from DataPath.
- `forward_A` out 2: 00 ID_EX, 10 EX_MEM, 11 WB.
- `forward_B` out 2: 00 ID_EX, 01 immediate, 10 EX_MEM, 11 WB.
- `forward_mem` out 1: store data from MEM_WB load.
- `pc_mux` out 2: 00 pc+1, 01 branch, 10 jump/call, 11 ret.
- `push`, `pop` out 1 each: stack controls.
- `pc_hold` out 1: PC keeps its value.
- `if_id_hold` out 1: IF_ID keeps its value.
- `id_ex_bubble` out 1: IF_ID-to-ID_EX control zeroed.
- `flush` out 1: IF_ID cleared.

## Operation
- **Shadow stages.** Three shadow stages, EX, MEM and WB, each hold: `valid`, `reg_write`, `is_load`, `flag_write`, `dst`, `srcA`, `srcB`, `imm_B`, `mem_write`.
  - On each clock, ID advances to EX, EX to MEM, and MEM to WB.
  - The ID entry is invalid, i.e. a bubble, when `id_ex_bubble` is set.
- **Forwarding A** (combinational from the EX stage):
  - If MEM.valid & MEM.reg_write & MEM.dst==EX.srcA, the output is 10.
  - Else if the same condition holds for WB, the output is 11.
  - Else 00.
  - MEM has priority over WB.
- **Forwarding B:** if EX.imm_B, the output is 01; otherwise the same rule as A, applied to srcB.
- **forward_mem** = MEM.mem_write & WB.valid & WB.is_load & WB.dst == MEM.srcB.
- **Load-use stall:** asserted when EX.valid & EX.is_load & EX.reg_write and either of these matches:
  - `id_uses_A` and srcA == EX.dst;
  - `id_uses_B` and srcB == EX.dst.
- **Flag stall:** asserted when `id_branch_sel`≠00 & EX.valid & EX.flag_write. The flags are not yet written.
- **stall** = load-use stall | flag stall. It drives `pc_hold`, `if_id_hold` and `id_ex_bubble` to 1.
- **Control transfer** (only when not stalled):
  - Taken branch: `pc_mux`=01, `flush`=1.
  - `id_jump`: `pc_mux`=10, `flush`=1.
  - `id_call`: `pc_mux`=10, `push`=1, `flush`=1.
  - `id_ret`: `pc_mux`=11, `pop`=1, `flush`=1.
  - Priority: ret > call > jump > branch.
- **Stall overrides transfer.** While stalled: `pc_mux`=00, `push`=`pop`=`flush`=0. The transfer is re-evaluated on the next cycle.
- **Flushed cycle.** The next ID instruction is a bubble; the IF_ID clear comes from `flush`. This block also forces its own ID-entry capture invalid in the cycle after `flush`.
- **Register 0** is an ordinary register and is not hard-wired to zero.

## Timing
- **Reset values:** all shadow `valid`=0; `forward_A`=`forward_B`=00; `forward_mem`=0; `pc_mux`=00; all other outputs 0.
- **Reset timing:** reset acts asynchronously mid-operation and discards in-flight metadata. The first cycle after release behaves as an empty pipeline.
- **Outputs:** all outputs are combinational from shadow state and ID inputs. Zero-cycle latency to the DataPath muxes.
- **Stall length:** a load-use stall lasts exactly 1 cycle, because the load moves to MEM and EX becomes a bubble. A flag stall also lasts 1 cycle.
- **Transfer penalty:** a taken transfer costs 1 flushed slot.
- **Simultaneous stall and transfer:** stall wins, and `push`/`pop` never fire twice for one call/ret.
- **Consecutive stalls:** cannot exceed 1 for the same ID instruction.

## Structure
- Package `hazard_pkg` holds:
  - localparams for the `forward_A`/`forward_B` codes (FWD_IDEX, FWD_IMM, FWD_MEM, FWD_WB);
  - localparams for the `pc_mux` codes (PC_INC, PC_BR, PC_JMP, PC_RET);
  - the `branch_sel` codes.
- Sub-module `hazard_stage_reg`: one shadow stage register with asynchronous reset and a bubble input. It is instantiated three times.
- The top level holds the forward, stall and transfer logic.

## Test plan
- **EX to EX forward:** ADD r1 followed by SUB using r1 as src A. The cycle the SUB is in EX gives `forward_A`=10 and no stall.
- **WB forward:** ADD r2, then an independent instruction, then a reader of r2 as src B with `id_alu_B_mux`=0. The reader's EX cycle gives `forward_B`=11.
- **Load-use:**
  - Stimulus: load r3, immediately followed by a reader of r3.
  - One cycle with `pc_hold`=`if_id_hold`=`id_ex_bubble`=1.
  - Next cycle: stall=0, and the reader's EX cycle gives `forward_A`=11.
- **Flag stall then branch:**
  - Stimulus: ADD with `flag_write`=1, followed by BZ with Z=1.
  - One stall cycle with `pc_mux`=00.
  - Next cycle: `pc_mux`=01, `flush`=1.
- **Call/ret:**
  - `id_call` gives `pc_mux`=10, `push`=1, `flush`=1 for exactly one cycle.
  - A later `id_ret` gives `pc_mux`=11, `pop`=1.
  - A call coinciding with a load-use stall holds `push`=0 until the stall clears.
- **Reset mid-run:** assert `reset` while a load is in EX. All outputs go to 0 immediately, and no stall occurs after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: select codes and branch evaluation shared by the hazard controller
package hazard_pkg;
    localparam logic [1:0] FWD_IDEX = 2'b00;
    localparam logic [1:0] FWD_IMM  = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b11;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
    localparam logic [1:0] PC_RET = 2'b11;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_Z    = 2'b01;
    localparam logic [1:0] BR_NZ   = 2'b10;
    localparam logic [1:0] BR_C    = 2'b11;

    function automatic logic br_taken(input logic [1:0] sel, input logic c, input logic z);
        return sel == BR_Z ? z : sel == BR_NZ ? !z : sel == BR_C ? c : 1'b0;
    endfunction
endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one shadow pipeline stage of instruction metadata with bubble insertion
module hazard_stage_reg #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bubble,
    input  logic         valid_d,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);
    // capture the upstream entry, or an empty slot when a bubble is inserted
    always_ff @(posedge clk or posedge reset)
        if (reset) {valid, q} <= '0;
        else {valid, q} <= bubble ? '0 : {valid_d, d};
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, stall and control-transfer sequencing for the 4-stage datapath
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int INST_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INST_W-1:0] id_inst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_alu_B_mux,
    input  logic              id_reg_B_mux,
    input  logic              id_flag_write,
    input  logic              id_uses_A,
    input  logic              id_uses_B,
    input  logic [1:0]        id_branch_sel,
    input  logic              id_jump,
    input  logic              id_call,
    input  logic              id_ret,
    input  logic              C,
    input  logic              Z,
    output logic [1:0]        forward_A,
    output logic [1:0]        forward_B,
    output logic              forward_mem,
    output logic [1:0]        pc_mux,
    output logic              push,
    output logic              pop,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              id_ex_bubble,
    output logic              flush
);
    localparam int W = 5 + 3 * REG_AW;

    logic [REG_AW-1:0] id_a, id_b, id_d;
    logic [W-1:0]      id_q, ex_q, mem_q, wb_q;
    logic              ex_v, mem_v, wb_v;
    logic              ex_rw, ex_ld, ex_fw, ex_imm, ex_mw;
    logic              mem_rw, mem_ld, mem_fw, mem_imm, mem_mw;
    logic              wb_rw, wb_ld, wb_fw, wb_imm, wb_mw;
    logic [REG_AW-1:0] ex_dst, ex_a, ex_b, mem_dst, mem_a, mem_b, wb_dst, wb_a, wb_b;
    logic              flush_d, ld_hit, fl_hit, stall, go, taken, unused;

    assign id_a = id_inst[8 +: REG_AW];
    assign id_d = id_inst[11 +: REG_AW];
    assign id_b = id_reg_B_mux ? id_d : id_inst[5 +: REG_AW];
    assign id_q = {id_reg_write, id_mem_read, id_flag_write, id_alu_B_mux, id_mem_write, id_d, id_a, id_b};

    assign {ex_rw, ex_ld, ex_fw, ex_imm, ex_mw, ex_dst, ex_a, ex_b}         = ex_q;
    assign {mem_rw, mem_ld, mem_fw, mem_imm, mem_mw, mem_dst, mem_a, mem_b} = mem_q;
    assign {wb_rw, wb_ld, wb_fw, wb_imm, wb_mw, wb_dst, wb_a, wb_b}         = wb_q;

    assign unused = ^{id_inst[INST_W-1:11+REG_AW], id_inst[4:0], mem_ld, mem_fw, mem_imm, mem_a,
                      wb_fw, wb_imm, wb_mw, wb_a, wb_b};

    hazard_stage_reg #(.W(W)) u_ex (
        .clk(clk), .reset(reset), .bubble(stall | flush_d), .valid_d(1'b1),
        .d(id_q), .valid(ex_v), .q(ex_q)
    );
    hazard_stage_reg #(.W(W)) u_mem (
        .clk(clk), .reset(reset), .bubble(1'b0), .valid_d(ex_v),
        .d(ex_q), .valid(mem_v), .q(mem_q)
    );
    hazard_stage_reg #(.W(W)) u_wb (
        .clk(clk), .reset(reset), .bubble(1'b0), .valid_d(mem_v),
        .d(mem_q), .valid(wb_v), .q(wb_q)
    );

    // remember a taken transfer so the slot fetched behind it enters EX as a bubble
    always_ff @(posedge clk or posedge reset)
        if (reset) flush_d <= 1'b0;
        else flush_d <= flush;

    assign forward_A = mem_v && mem_rw && mem_dst == ex_a ? FWD_MEM :
                       wb_v && wb_rw && wb_dst == ex_a ? FWD_WB : FWD_IDEX;
    assign forward_B = ex_imm ? FWD_IMM :
                       mem_v && mem_rw && mem_dst == ex_b ? FWD_MEM :
                       wb_v && wb_rw && wb_dst == ex_b ? FWD_WB : FWD_IDEX;
    assign forward_mem = mem_mw && wb_v && wb_ld && wb_dst == mem_b;

    assign ld_hit = ex_v && ex_ld && ex_rw && ((id_uses_A && id_a == ex_dst) || (id_uses_B && id_b == ex_dst));
    assign fl_hit = id_branch_sel != BR_NONE && ex_v && ex_fw;
    assign stall  = !reset && (ld_hit || fl_hit);
    assign go     = !reset && !stall;
    assign taken  = br_taken(id_branch_sel, C, Z);

    assign pc_hold      = stall;
    assign if_id_hold   = stall;
    assign id_ex_bubble = stall;

    assign pc_mux = !go ? PC_INC : id_ret ? PC_RET : (id_call || id_jump) ? PC_JMP : taken ? PC_BR : PC_INC;
    assign push   = go && id_call && !id_ret;
    assign pop    = go && id_ret;
    assign flush  = go && (id_ret || id_call || id_jump || taken);
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl against an instruction-history reference model
module tb_hazard_ctrl;
    typedef struct {
        bit rw, mr, mw, amux, bmux, fw, ua, ub, jmp, call, ret, c, z, rst;
        bit [1:0] br;
        bit [18:0] inst;
    } stim_t;

    typedef struct {
        bit v, rw, ld, fw, mw, imm;
        bit [2:0] dst, a, b;
    } ent_t;

    typedef struct {
        bit [1:0] fa, fb, pc;
        bit fm, push, pop, hold, flush;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] id_inst = '0;
    logic        id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, id_alu_B_mux = 0, id_reg_B_mux = 0;
    logic        id_flag_write = 0, id_uses_A = 0, id_uses_B = 0, id_jump = 0, id_call = 0, id_ret = 0;
    logic [1:0]  id_branch_sel = '0;
    logic        C = 0, Z = 0;
    logic [1:0]  forward_A, forward_B, pc_mux;
    logic        forward_mem, push, pop, pc_hold, if_id_hold, id_ex_bubble, flush;

    int n_chk = 0;
    int n_fail = 0;
    out_t  exp_q[$];
    stim_t dq[$];
    ent_t  hist[3];
    bit    fl_prev = 0, last_stall = 0, last_flush = 0;

    hazard_ctrl #(.REG_AW(3), .INST_W(19)) dut (
        .clk(clk), .reset(reset), .id_inst(id_inst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_alu_B_mux(id_alu_B_mux), .id_reg_B_mux(id_reg_B_mux), .id_flag_write(id_flag_write),
        .id_uses_A(id_uses_A), .id_uses_B(id_uses_B), .id_branch_sel(id_branch_sel),
        .id_jump(id_jump), .id_call(id_call), .id_ret(id_ret), .C(C), .Z(Z),
        .forward_A(forward_A), .forward_B(forward_B), .forward_mem(forward_mem), .pc_mux(pc_mux),
        .push(push), .pop(pop), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
        .id_ex_bubble(id_ex_bubble), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic stim_t mk(input int k, input bit [2:0] d, input bit [2:0] a, input bit [2:0] b);
        stim_t s;
        s = '{default: 0};
        s.inst = 19'($urandom);
        s.inst[13:11] = d;
        s.inst[10:8] = a;
        s.inst[7:5] = b;
        case (k)
            0: begin s.rw = 1; s.ua = 1; s.ub = 1; s.fw = 1; end
            1: begin s.rw = 1; s.ua = 1; s.amux = 1; s.fw = 1; end
            2: begin s.rw = 1; s.mr = 1; s.ua = 1; s.amux = 1; end
            3: begin s.mw = 1; s.ua = 1; s.ub = 1'($urandom); s.bmux = 1; end
            4: s.br = 2'($urandom_range(1, 3));
            5: s.jmp = 1;
            6: s.call = 1;
            7: s.ret = 1;
            default: ;
        endcase
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        int k;
        k = $urandom_range(0, 8);
        s = mk(k, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)));
        if (k < 2) s.fw = 1'($urandom);
        s.c = 1'($urandom);
        s.z = 1'($urandom);
        s.rst = ($urandom_range(0, 249) == 0);
        return s;
    endfunction

    // what this instruction looks like once it has been issued into EX
    function automatic ent_t entry(input stim_t s);
        ent_t e;
        e.v = 1; e.rw = s.rw; e.ld = s.mr; e.fw = s.fw; e.mw = s.mw; e.imm = s.amux;
        e.dst = s.inst[13:11];
        e.a = s.inst[10:8];
        e.b = s.bmux ? s.inst[13:11] : s.inst[7:5];
        return e;
    endfunction

    // nearest older writer of src: one step ahead is EX_MEM, two steps ahead is WB
    function automatic bit [1:0] fwd_of(input bit [2:0] src);
        for (int k = 1; k < 3; k++)
            if (hist[k].v && hist[k].rw && hist[k].dst == src) return k == 1 ? 2'b10 : 2'b11;
        return 2'b00;
    endfunction

    task automatic cycle(input stim_t s);
        out_t o;
        ent_t id, ex;
        bit st, tk;
        reset = s.rst; id_inst = s.inst;
        id_reg_write = s.rw; id_mem_read = s.mr; id_mem_write = s.mw; id_alu_B_mux = s.amux;
        id_reg_B_mux = s.bmux; id_flag_write = s.fw; id_uses_A = s.ua; id_uses_B = s.ub;
        id_branch_sel = s.br; id_jump = s.jmp; id_call = s.call; id_ret = s.ret; C = s.c; Z = s.z;
        o = '{default: 0};
        id = entry(s);
        ex = hist[0];
        st = 0;
        if (!s.rst) begin
            st = (ex.v && ex.ld && ex.rw && ((s.ua && id.a == ex.dst) || (s.ub && id.b == ex.dst)))
                 || (s.br != 0 && ex.v && ex.fw);
            o.fa = fwd_of(ex.a);
            o.fb = ex.imm ? 2'b01 : fwd_of(ex.b);
            o.fm = hist[1].mw && hist[2].v && hist[2].ld && hist[2].dst == hist[1].b;
            o.hold = st;
            tk = s.br == 1 ? s.z : s.br == 2 ? !s.z : s.br == 3 ? s.c : 1'b0;
            if (!st) begin
                if (s.ret) begin o.pc = 3; o.pop = 1; o.flush = 1; end
                else if (s.call) begin o.pc = 2; o.push = 1; o.flush = 1; end
                else if (s.jmp) begin o.pc = 2; o.flush = 1; end
                else if (tk) begin o.pc = 1; o.flush = 1; end
            end
        end
        exp_q.push_back(o);
        @(posedge clk);
        if (s.rst) begin
            foreach (hist[k]) hist[k] = '{default: 0};
            fl_prev = 0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = (st || fl_prev) ? '{default: 0} : id;
            fl_prev = o.flush;
        end
        last_stall = st;
        last_flush = o.flush;
        #1;
    endtask

    initial begin : monitor
        out_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("forward_A", forward_A, e.fa);
                chk("forward_B", forward_B, e.fb);
                chk("forward_mem", forward_mem, e.fm);
                chk("pc_mux", pc_mux, e.pc);
                chk("push", push, e.push);
                chk("pop", pop, e.pop);
                chk("flush", flush, e.flush);
                chk("pc_hold", pc_hold, e.hold);
                chk("if_id_hold", if_id_hold, e.hold);
                chk("id_ex_bubble", id_ex_bubble, e.hold);
            end
        end
    end

    initial begin : stimulus
        stim_t cur, s;
        foreach (hist[k]) hist[k] = '{default: 0};
        s = mk(6, 0, 0, 0); s.rst = 1; dq.push_back(s); dq.push_back(s);
        dq.push_back(mk(0, 1, 2, 3)); dq.push_back(mk(0, 4, 1, 5));
        dq.push_back(mk(0, 2, 0, 0)); dq.push_back(mk(0, 6, 7, 7)); dq.push_back(mk(0, 5, 4, 2));
        dq.push_back(mk(2, 3, 0, 0)); dq.push_back(mk(0, 4, 3, 1));
        dq.push_back(mk(8, 0, 0, 0)); dq.push_back(mk(8, 0, 0, 0));
        dq.push_back(mk(0, 1, 2, 2));
        s = mk(4, 0, 0, 0); s.br = 1; s.z = 1; dq.push_back(s);
        dq.push_back(mk(6, 0, 0, 0)); dq.push_back(mk(8, 0, 0, 0)); dq.push_back(mk(7, 0, 0, 0));
        dq.push_back(mk(2, 3, 0, 0));
        s = mk(6, 0, 3, 0); s.ua = 1; dq.push_back(s);
        dq.push_back(mk(2, 3, 1, 1));
        s = mk(0, 4, 3, 3); s.jmp = 1; s.rst = 1; dq.push_back(s); dq.push_back(s);
        s.rst = 0; dq.push_back(s);
        @(posedge clk);
        #1;
        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) begin
                if (last_flush) cur = mk(8, 0, 0, 0);
                else if (dq.size() > 0) cur = dq.pop_front();
                else cur = rnd();
            end
            cycle(cur);
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
